// File: rtl/cga_text_pixel.sv
// CGA text-mode pixel pipeline behind the 6845: fetches char/attr/glyph per
// character clock, then serialises 8 IRGB pixels with blink, cursor and border.
module cga_text_pixel #(
  parameter int BLINK_BIT    = 4,
  parameter int FETCH_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        divclk,
  input  logic [13:0] mem_addr,
  input  logic [4:0]  row_addr,
  input  logic        display_enable,
  input  logic        cursor,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        blink_en,
  input  logic [3:0]  border,
  output logic [13:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [11:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [3:0]  video,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out
);

  // The final fetch state is the one that lands FETCH_CYCLES-1 clocks after divclk.
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_C1   = 3'd1;
  localparam logic [2:0] S_C2   = 3'd2;
  localparam logic [2:0] S_C3   = 3'd3;
  localparam logic [2:0] S_C4   = 3'(FETCH_CYCLES - 1);

  logic [2:0]  state;
  logic [12:0] cap_ma;
  logic [3:0]  cap_row;
  logic        cap_cursor;
  logic        cap_de;
  logic        cap_hs;
  logic        cap_vs;
  logic [7:0]  f_char;
  logic [7:0]  f_attr;
  logic [7:0]  f_glyph;
  logic        ready;
  logic [4:0]  frame_cnt;

  logic [7:0]  shreg;
  logic [3:0]  out_fg;
  logic [3:0]  out_bg;
  logic        out_de;

  logic [7:0]  ld_attr;
  logic [7:0]  ld_mask;
  logic [3:0]  ld_fg;
  logic [3:0]  ld_bg;
  logic [3:0]  ld_pixel;
  logic [3:0]  run_pixel;
  logic        blink_phase;

  logic        unused_bits;
  assign unused_bits = ^{mem_addr[13], row_addr[4], f_char};

  // Capture stage, fetch sequencer and frame counter; divclk always restarts the fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cap_ma     <= '0;
      cap_row    <= '0;
      cap_cursor <= 1'b0;
      cap_de     <= 1'b0;
      cap_hs     <= 1'b0;
      cap_vs     <= 1'b0;
      f_char     <= '0;
      f_attr     <= '0;
      f_glyph    <= '0;
      ready      <= 1'b0;
      frame_cnt  <= '0;
      vram_addr  <= '0;
      vram_rd    <= 1'b0;
      font_addr  <= '0;
    end else if (divclk) begin
      cap_ma     <= mem_addr[12:0];
      cap_row    <= row_addr[3:0];
      cap_cursor <= cursor;
      cap_de     <= display_enable;
      cap_hs     <= hsync_in;
      cap_vs     <= vsync_in;
      vram_addr  <= {mem_addr[12:0], 1'b0};
      vram_rd    <= 1'b1;
      ready      <= 1'b0;
      state      <= S_C1;
      if (state != S_IDLE) begin
        f_char  <= '0;
        f_attr  <= '0;
        f_glyph <= '0;
      end
      if (vsync_in && !cap_vs) begin
        frame_cnt <= frame_cnt + 5'd1;
      end
    end else begin
      case (state)
        S_C1: begin
          vram_addr <= {cap_ma, 1'b1};
          vram_rd   <= 1'b1;
          state     <= S_C2;
        end
        S_C2: begin
          f_char    <= vram_data;
          font_addr <= {vram_data, cap_row};
          vram_rd   <= 1'b0;
          state     <= S_C3;
        end
        S_C3: begin
          f_attr <= vram_data;
          state  <= S_C4;
        end
        S_C4: begin
          f_glyph <= font_data;
          ready   <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // An unfinished fetch loads as a blank character with colour 0 on 0.
  always_comb begin
    blink_phase = frame_cnt[BLINK_BIT];
    ld_attr     = ready ? f_attr : 8'h00;
    ld_fg       = ld_attr[3:0];
    ld_bg       = {ld_attr[7] & ~blink_en, ld_attr[6:4]};
    if (cap_cursor && blink_phase) begin
      ld_mask = 8'hFF;
    end else if (blink_en && ld_attr[7] && !blink_phase) begin
      ld_mask = 8'h00;
    end else begin
      ld_mask = ready ? f_glyph : 8'h00;
    end
    ld_pixel  = cap_de ? (ld_mask[7] ? ld_fg : ld_bg) : border;
    run_pixel = out_de ? (shreg[7] ? out_fg : out_bg) : border;
  end

  // Output shifter: the first pixel is registered on the load edge itself.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      out_fg    <= '0;
      out_bg    <= '0;
      out_de    <= 1'b0;
      video     <= '0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      de_out    <= 1'b0;
    end else if (divclk) begin
      shreg     <= {ld_mask[6:0], 1'b0};
      out_fg    <= ld_fg;
      out_bg    <= ld_bg;
      out_de    <= cap_de;
      video     <= ld_pixel;
      hsync_out <= cap_hs;
      vsync_out <= cap_vs;
      de_out    <= cap_de;
    end else begin
      shreg <= {shreg[6:0], 1'b0};
      video <= run_pixel;
    end
  end

endmodule

// File: tb/tb_cga_text_pixel.sv
// Bench for cga_text_pixel: VRAM/font models, a pulse-history reference model
// compared every cycle, and literal pixel patterns for the key cases.
module tb_cga_text_pixel;

  localparam int FETCH_CYCLES = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        divclk = 1'b0;
  logic [13:0] mem_addr = '0;
  logic [4:0]  row_addr = '0;
  logic        display_enable = 1'b0;
  logic        cursor = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic        blink_en = 1'b1;
  logic [3:0]  border = 4'h5;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data = '0;
  logic [11:0] font_addr;
  logic [7:0]  font_data = '0;
  logic [3:0]  video;
  logic        hsync_out;
  logic        vsync_out;
  logic        de_out;

  logic [7:0] vram [0:16383];
  logic [7:0] font [0:4095];

  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  cga_text_pixel #(.BLINK_BIT(4), .FETCH_CYCLES(FETCH_CYCLES)) dut (
    .clk(clk), .reset(reset), .divclk(divclk), .mem_addr(mem_addr),
    .row_addr(row_addr), .display_enable(display_enable), .cursor(cursor),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .blink_en(blink_en),
    .border(border), .vram_addr(vram_addr), .vram_rd(vram_rd),
    .vram_data(vram_data), .font_addr(font_addr), .font_data(font_data),
    .video(video), .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out)
  );

  // Synchronous VRAM and font ROM: data one clock after the address.
  always @(posedge clk) begin
    vram_data <= vram[vram_addr];
    font_data <= font[font_addr];
  end

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a character latched at one pulse is shown after the next,
  // blank if the gap between the pulses was too short to finish the fetch.
  int          cyc = 0;
  int          prev_t = 0;
  bit          have_prev = 0;
  logic [13:0] s_ma = '0;
  logic [3:0]  s_row = '0;
  bit          s_cur = 0, s_de = 0, s_hs = 0, s_vs = 0;
  int          frames = 0;
  logic [7:0]  m_mask = '0;
  logic [3:0]  m_fg = '0, m_bg = '0;
  bit          m_de = 0, m_hs = 0, m_vs = 0;
  int          m_idx = 8;
  logic [3:0]  exp_video = '0;

  always @(posedge clk or posedge reset) begin
    bit ok, phase;
    logic [7:0] ch, at, gl;
    if (reset) begin
      cyc = 0; prev_t = 0; have_prev = 0;
      s_ma = '0; s_row = '0; s_cur = 0; s_de = 0; s_hs = 0; s_vs = 0;
      frames = 0; m_mask = '0; m_fg = '0; m_bg = '0;
      m_de = 0; m_hs = 0; m_vs = 0; m_idx = 8; exp_video = '0;
    end else begin
      if (divclk) begin
        ok = have_prev && (cyc - prev_t >= FETCH_CYCLES);
        ch = ok ? vram[{s_ma[12:0], 1'b0}] : 8'h00;
        at = ok ? vram[{s_ma[12:0], 1'b1}] : 8'h00;
        gl = ok ? font[{ch, s_row}] : 8'h00;
        phase = ((frames / 16) % 2) == 1;
        m_fg = at[3:0];
        m_bg = {at[7] && !blink_en, at[6:4]};
        if (s_cur && phase) m_mask = 8'hFF;
        else if (blink_en && at[7] && !phase) m_mask = 8'h00;
        else m_mask = gl;
        m_de = s_de; m_hs = s_hs; m_vs = s_vs; m_idx = 0;
        if (vsync_in && !s_vs) frames = (frames + 1) % 32;
        s_ma = mem_addr; s_row = row_addr[3:0]; s_cur = cursor;
        s_de = display_enable; s_hs = hsync_in; s_vs = vsync_in;
        have_prev = 1; prev_t = cyc;
      end else if (m_idx < 8) begin
        m_idx++;
      end
      if (!m_de) exp_video = border;
      else if (m_idx < 8 && m_mask[7 - m_idx]) exp_video = m_fg;
      else exp_video = m_bg;
      cyc++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check_output("video", 16'(video), 16'(exp_video));
    check_output("hsync_out", 16'(hsync_out), 16'(m_hs));
    check_output("vsync_out", 16'(vsync_out), 16'(m_vs));
    check_output("de_out", 16'(de_out), 16'(m_de));
  end

  // One character period: latch new CRTC inputs, optionally pin pixels of the loaded character.
  task automatic apply_stimulus(input logic [13:0] ma, input logic [4:0] row,
                                input logic de, input logic cur, input logic hs,
                                input logic vs, input int gap, input bit lit_en,
                                input logic [31:0] lit, input string name);
    mem_addr = ma; row_addr = row; display_enable = de; cursor = cur;
    hsync_in = hs; vsync_in = vs; divclk = 1'b1;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      divclk = 1'b0;
      if (lit_en && i < 8) check_output(name, 16'(video), 16'(lit[31 - 4*i -: 4]));
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
    for (int i = 0; i < 4096; i++) font[i] = 8'h00;
    vram[0] = 8'h41; vram[1] = 8'h1E;
    vram[2] = 8'h42; vram[3] = 8'h9E;
    vram[4] = 8'h43; vram[5] = 8'h70;
    font[12'h413] = 8'h18;
    font[12'h423] = 8'h3C;
    font[12'h433] = 8'h81;

    repeat (3) @(negedge clk);
    check_output("rst_video", 16'(video), 16'h0);
    check_output("rst_vram_rd", 16'(vram_rd), 16'h0);
    check_output("rst_vram_addr", 16'(vram_addr), 16'h0);
    check_output("rst_font_addr", 16'(font_addr), 16'h0);
    check_output("rst_de_out", 16'(de_out), 16'h0);
    reset = 1'b0;

    apply_stimulus(14'h0000, 5'd3, 1, 0, 0, 0, 8, 0, 32'h0, "");
    apply_stimulus(14'h2000, 5'd19, 1, 0, 0, 0, 8, 1, 32'h111EE111, "normal");
    apply_stimulus(14'h0002, 5'd3, 1, 0, 0, 0, 8, 1, 32'h111EE111, "addr_alias");
    apply_stimulus(14'h0001, 5'd3, 1, 0, 0, 0, 8, 1, 32'h07777770, "attr70");
    apply_stimulus(14'h0001, 5'd3, 1, 0, 0, 0, 8, 1, 32'h11111111, "blink_hidden");
    for (int k = 0; k < 16; k++) begin
      apply_stimulus(14'h0001, 5'd3, 1, 0, 0, 1, 8, 0, 32'h0, "");
      apply_stimulus(14'h0001, 5'd3, 1, 0, 0, 0, 8, 0, 32'h0, "");
    end
    apply_stimulus(14'h0001, 5'd3, 1, 0, 0, 0, 8, 1, 32'h11EEEE11, "blink_shown");
    blink_en = 1'b0;
    apply_stimulus(14'h0001, 5'd3, 1, 0, 0, 0, 8, 1, 32'h99EEEE99, "blink_disabled");
    blink_en = 1'b1;
    apply_stimulus(14'h0000, 5'd3, 1, 1, 0, 0, 8, 0, 32'h0, "");
    apply_stimulus(14'h0000, 5'd3, 0, 0, 0, 0, 8, 1, 32'hEEEEEEEE, "cursor");
    apply_stimulus(14'h0000, 5'd3, 1, 0, 1, 0, 8, 1, 32'h55555555, "border");
    check_output("border_de_out", 16'(de_out), 16'h0);

    check_output("hsync_before", 16'(hsync_out), 16'h0);
    mem_addr = 14'h0000; hsync_in = 1'b0; divclk = 1'b1;
    @(negedge clk);
    divclk = 1'b0;
    check_output("hsync_first", 16'(hsync_out), 16'h1);
    check_output("hsync_pixel", 16'(video), 16'h1);
    repeat (7) @(negedge clk);

    apply_stimulus(14'h0000, 5'd3, 1, 0, 0, 0, 3, 0, 32'h0, "");
    apply_stimulus(14'h0002, 5'd3, 1, 0, 0, 0, 8, 1, 32'h00000000, "abort_blank");
    apply_stimulus(14'h0001, 5'd3, 1, 0, 0, 0, 8, 1, 32'h07777770, "abort_recover");

    divclk = 1'b1;
    repeat (3) @(negedge clk);
    check_output("held_divclk", 16'(video), 16'h0);
    repeat (5) @(negedge clk);
    divclk = 1'b0;
    repeat (8) @(negedge clk);

    mem_addr = 14'h0001; display_enable = 1'b1; divclk = 1'b1;
    @(negedge clk);
    divclk = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_output("midrst_video", 16'(video), 16'h0);
    check_output("midrst_vram_rd", 16'(vram_rd), 16'h0);
    check_output("midrst_vram_addr", 16'(vram_addr), 16'h0);
    check_output("midrst_font_addr", 16'(font_addr), 16'h0);
    check_output("midrst_de_out", 16'(de_out), 16'h0);
    @(negedge clk);
    reset = 1'b0;
    apply_stimulus(14'h0000, 5'd3, 1, 0, 0, 0, 8, 1, 32'h55555555, "post_reset_first");
    apply_stimulus(14'h0002, 5'd3, 1, 0, 0, 0, 8, 1, 32'h111EE111, "post_reset_valid");
    repeat (2) @(negedge clk);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
